drp_start_seq: RTL and testbench

Parametrised successor to the single-channel DRP start controller. The block counts qualified `count_done` events up to a programmable start delay, then issues per-channel DRP start pulses in sequence. Each pulse is followed by a `drp_done` handshake, or by a timeout, before the next channel starts. It sits between the clock-ready/lock counter logic and the NUM_CH DRP reconfiguration engines, and can be re-armed without a global reset.

---
 rtl/drp_seq_pkg.sv | 36 +++
 rtl/drp_wait_timer.sv | 36 +++
 rtl/drp_start_seq.sv | 134 +++++++++++++
 tb/tb_drp_start_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/drp_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | drp_seq_pkg                                                          |
// | State encoding, width helper and parameter range checks for the DRP  |
// | start sequencer.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package drp_seq_pkg;

  typedef enum logic [2:0] {
    ST_COUNT = 3'd0,
    ST_PULSE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Ceiling log2 that never returns less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic bit params_legal(input int num_ch, input int start_dly,
                                      input int cnt_w, input int pulse_w,
                                      input int timeout);
    return (num_ch >= 1) && (num_ch <= 16) &&
           (cnt_w >= 1) && (cnt_w <= 30) &&
           (start_dly >= 1) && (start_dly <= (1 << cnt_w) - 1) &&
           (pulse_w >= 1) && (timeout >= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/drp_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | drp_wait_timer                                                       |
// | Loadable down-counter with enable and terminal-count flag, shared    |
// | by the pulse-width and handshake-wait phases.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module drp_wait_timer
  import drp_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_term = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/drp_start_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | drp_start_seq                                                        |
// | Counts qualified events up to a start delay, then pulses each DRP    |
// | channel in turn and waits for its done handshake or a timeout.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module drp_start_seq
  import drp_seq_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int START_DLY = 6,
  parameter int CNT_W     = 3,
  parameter int PULSE_W   = 1,
  parameter int TIMEOUT   = 200,
  localparam int CH_W     = clog2_min1(NUM_CH)
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              count_done,
  input  logic              rearm,
  input  logic [NUM_CH-1:0] drp_done,
  output logic [NUM_CH-1:0] drp_start,
  output logic [CH_W-1:0]   cur_ch,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [NUM_CH-1:0] timeout_err
);

  localparam int TW = clog2_min1((PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT);
  localparam logic [CNT_W-1:0] c_START_DLY = CNT_W'(START_DLY);
  localparam logic [CH_W-1:0]  c_LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [TW-1:0]    c_PULSE_LD  = TW'(PULSE_W - 1);
  localparam logic [TW-1:0]    c_WAIT_LD   = TW'(TIMEOUT - 1);

  if (!params_legal(NUM_CH, START_DLY, CNT_W, PULSE_W, TIMEOUT)) begin : g_param_check
    $error("drp_start_seq: parameter out of legal range");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_cur_ch;
  logic [NUM_CH-1:0] r_timeout_err;
  logic [NUM_CH-1:0] w_sel;
  logic              w_done_cur;
  logic              w_term;
  logic              w_tmr_load;
  logic              w_tmr_en;
  logic [TW-1:0]     w_tmr_val;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel[i] = (r_cur_ch == CH_W'(i));
    end
  end

  // Only the serviced channel's handshake bit can advance the sequence.
  assign w_done_cur = |(drp_done & w_sel);

  drp_wait_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clkin),
    .rst        (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_term     (w_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = c_PULSE_LD;
    w_tmr_en    = 1'b0;
    case (r_state)
      ST_COUNT: begin
        w_tmr_load = 1'b1;
        if (r_cnt == c_START_DLY) w_state_nxt = ST_PULSE;
      end
      ST_PULSE: begin
        if (w_term) begin
          w_state_nxt = ST_WAIT;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_WAIT_LD;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_done_cur || w_term) w_state_nxt = ST_NEXT;
        else                      w_tmr_en    = 1'b1;
      end
      ST_NEXT: begin
        w_tmr_load  = 1'b1;
        w_state_nxt = (r_cur_ch == c_LAST_CH) ? ST_DONE : ST_PULSE;
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_COUNT;
    endcase
    if (rearm) w_state_nxt = ST_COUNT;
  end

  always_ff @(posedge clkin) begin
    if (reset) r_state <= ST_COUNT;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clkin) begin
    if (reset || rearm) begin
      r_cnt         <= '0;
      r_cur_ch      <= '0;
      r_timeout_err <= '0;
    end else begin
      if ((r_state == ST_COUNT) && count_done && (r_cnt != c_START_DLY))
        r_cnt <= r_cnt + CNT_W'(1);
      if ((r_state == ST_NEXT) && (r_cur_ch != c_LAST_CH))
        r_cur_ch <= r_cur_ch + CH_W'(1);
      // A done arriving on the final wait cycle takes precedence over the timeout.
      if ((r_state == ST_WAIT) && !w_done_cur && w_term)
        r_timeout_err <= r_timeout_err | w_sel;
    end
  end

  assign drp_start   = (r_state == ST_PULSE) ? w_sel : '0;
  assign cur_ch      = r_cur_ch;
  assign seq_busy    = (r_state == ST_PULSE) || (r_state == ST_WAIT) || (r_state == ST_NEXT);
  assign seq_done    = (r_state == ST_DONE);
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_drp_start_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_drp_start_seq                                                     |
// | Table-driven bench for drp_start_seq with hand-written corner cases. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_drp_start_seq;

  typedef struct {
    logic       cd;
    logic       rearm;
    logic [3:0] done;
    logic [3:0] start;
    logic       busy;
    logic       sdone;
    logic [3:0] terr;
    logic [1:0] ch;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c, cd, rearm;
  logic [3:0] done;
  logic [3:0] start_a, start_b, terr_a, terr_b;
  logic [1:0] ch_a, ch_b;
  logic       busy_a, busy_b, sdone_a, sdone_b;
  logic       start_c, terr_c, busy_c, sdone_c;
  logic [0:0] ch_c;

  drp_start_seq u_dut_a (
    .clkin (clk), .reset (rst_a), .count_done (cd), .rearm (rearm),
    .drp_done (done), .drp_start (start_a), .cur_ch (ch_a),
    .seq_busy (busy_a), .seq_done (sdone_a), .timeout_err (terr_a)
  );

  drp_start_seq #(.PULSE_W (2), .TIMEOUT (5)) u_dut_b (
    .clkin (clk), .reset (rst_b), .count_done (cd), .rearm (rearm),
    .drp_done (done), .drp_start (start_b), .cur_ch (ch_b),
    .seq_busy (busy_b), .seq_done (sdone_b), .timeout_err (terr_b)
  );

  drp_start_seq #(.NUM_CH (1)) u_dut_c (
    .clkin (clk), .reset (rst_c), .count_done (cd), .rearm (rearm),
    .drp_done (done[0:0]), .drp_start (start_c), .cur_ch (ch_c),
    .seq_busy (busy_c), .seq_done (sdone_c), .timeout_err (terr_c)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t tbl[$];
  int   resp[4];
  int   st[4];
  int   we[4];
  bit   to[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Expected timeline: start of channel k, end of its wait, NEXT one cycle later.
  task automatic build(input int pw, input int tmo, input bit sparse, input int tail);
    int   s;
    int   last;
    vec_t v;
    tbl.delete();
    s = sparse ? 22 : 7;
    for (int k = 0; k < 4; k++) begin
      st[k] = s;
      if (resp[k] >= pw && resp[k] <= pw + tmo - 1) begin
        we[k] = s + resp[k];
        to[k] = 1'b0;
      end else begin
        we[k] = s + pw + tmo - 1;
        to[k] = 1'b1;
      end
      s = we[k] + 2;
    end
    last = we[3] + 2 + tail;
    for (int c = 0; c <= last; c++) begin
      v.cd    = sparse ? ((c % 4) == 0) : 1'b1;
      v.rearm = 1'b0;
      v.done  = '0;
      v.start = '0;
      v.busy  = 1'b0;
      v.terr  = '0;
      v.ch    = '0;
      v.sdone = (c > we[3] + 1);
      if (v.sdone) v.ch = 2'd3;
      for (int k = 0; k < 4; k++) begin
        if (c >= st[k] && c <= we[k] + 1) begin
          v.busy = 1'b1;
          v.ch   = 2'(k);
        end
        if (c >= st[k] && c < st[k] + pw) v.start[k] = 1'b1;
        if (resp[k] >= 0 && c == st[k] + resp[k]) v.done[k] = 1'b1;
        if (sparse && c == st[k]) v.done[k] = 1'b1;
        if (sparse && c == st[k] + pw) v.done = v.done | (4'hF & ~(4'(1) << k));
        if (to[k] && c > we[k]) v.terr[k] = 1'b1;
      end
      tbl.push_back(v);
    end
  endtask

  task automatic hold_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    cd = 1'b0; rearm = 1'b0; done = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_table(input bit use_b, input string tag);
    hold_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      if (use_b) rst_b = 1'b0;
      else       rst_a = 1'b0;
      cd    = tbl[i].cd;
      rearm = tbl[i].rearm;
      done  = tbl[i].done;
      #4;
      check($sformatf("%s c%0d drp_start", tag, i), use_b ? start_b : start_a, tbl[i].start);
      check($sformatf("%s c%0d seq_busy", tag, i),  use_b ? busy_b  : busy_a,  tbl[i].busy);
      check($sformatf("%s c%0d seq_done", tag, i),  use_b ? sdone_b : sdone_a, tbl[i].sdone);
      check($sformatf("%s c%0d timeout_err", tag, i), use_b ? terr_b : terr_a, tbl[i].terr);
      check($sformatf("%s c%0d cur_ch", tag, i),    use_b ? ch_b    : ch_a,    tbl[i].ch);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;

    resp = '{3, 3, 3, 3};
    build(1, 200, 1'b0, 3);
    run_table(1'b0, "defaults");

    build(1, 200, 1'b1, 3);
    run_table(1'b0, "sparse");

    resp = '{3, -1, 3, 3};
    build(2, 5, 1'b0, 3);
    run_table(1'b1, "timeout");

    resp = '{6, 3, 3, 3};
    build(2, 5, 1'b0, 2);
    run_table(1'b1, "done_at_timeout");

    // Abort with rearm on the first PULSE cycle of channel 2 (cycle 20).
    resp = '{3, -1, 3, 3};
    build(2, 5, 1'b0, 0);
    while (tbl.size() > 21) void'(tbl.pop_back());
    v = tbl[20];
    v.rearm = 1'b1;
    tbl[20] = v;
    for (int c = 21; c <= 29; c++) begin
      v.cd = 1'b1; v.rearm = 1'b0; v.done = '0; v.sdone = 1'b0;
      v.terr = '0; v.ch = '0;
      v.busy  = (c >= 28);
      v.start = (c >= 28) ? 4'b0001 : 4'b0000;
      tbl.push_back(v);
    end
    run_table(1'b1, "rearm");

    // Reset while channel 1 waits, after channel 0 has timed out.
    hold_reset();
    for (int c = 0; c <= 19; c++) begin
      @(posedge clk); #1;
      rst_b = (c == 18);
      cd    = 1'b1;
      done  = '0;
      #4;
      if (c == 16) check("rstwait c16 drp_start", start_b, 4'b0010);
      if (c == 18) begin
        check("rstwait c18 seq_busy", busy_b, 1'b1);
        check("rstwait c18 timeout_err", terr_b, 4'b0001);
        check("rstwait c18 cur_ch", ch_b, 2'd1);
      end
      if (c == 19) begin
        check("rstwait c19 drp_start", start_b, 4'b0000);
        check("rstwait c19 seq_busy", busy_b, 1'b0);
        check("rstwait c19 seq_done", sdone_b, 1'b0);
        check("rstwait c19 timeout_err", terr_b, 4'b0000);
        check("rstwait c19 cur_ch", ch_b, 2'd0);
      end
    end

    // Single channel: start at 7, done answered at 9, DONE from 11.
    hold_reset();
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); #1;
      rst_c = 1'b0;
      cd    = 1'b1;
      done  = (c == 9) ? 4'b0001 : 4'b0000;
      #4;
      if (c == 6) check("onech c6 drp_start", start_c, 1'b0);
      if (c == 7) check("onech c7 drp_start", start_c, 1'b1);
      if (c == 8) check("onech c8 drp_start", start_c, 1'b0);
      if (c == 10) begin
        check("onech c10 seq_busy", busy_c, 1'b1);
        check("onech c10 seq_done", sdone_c, 1'b0);
      end
      if (c == 11 || c == 13) begin
        check($sformatf("onech c%0d seq_done", c), sdone_c, 1'b1);
        check($sformatf("onech c%0d seq_busy", c), busy_c, 1'b0);
        check($sformatf("onech c%0d cur_ch", c), ch_c, 1'b0);
        check($sformatf("onech c%0d timeout_err", c), terr_c, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
